led_spi_tx: RTL and testbench

Serial transmit stage that drives the LED matrix driver chip's 3-wire interface (CS, CLK_9M, DOUT) inside `top`. It accepts 16-bit command words (8-bit register address, 8-bit data) from the upstream pattern/sequencer logic over a valid/ready handshake. It shifts each word out MSB-first on a divided serial clock and frames it with CS so the device latches the word on the CS rising edge.

---
 rtl/led_pkg.sv | 27 ++
 rtl/led_spi_phase.sv | 52 +++++
 rtl/led_spi_tx.sv | 108 ++++++++++
 tb/tb_led_spi_tx.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED matrix driver serial link.
// Register addresses follow the MAX7219-style map used by the upstream sequencer.
package led_pkg;

  localparam int LED_WORD_W  = 16;
  localparam int LED_CLK_DIV = 3;
  localparam int LED_GAP_CYC = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    END   = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

  localparam logic [7:0] NOOP      = 8'h00;
  localparam logic [7:0] DECODE    = 8'h09;
  localparam logic [7:0] INTENSITY = 8'h0A;
  localparam logic [7:0] SCANLIMIT = 8'h0B;
  localparam logic [7:0] SHUTDOWN  = 8'h0C;
  localparam logic [7:0] TEST      = 8'h0F;

  function automatic logic [15:0] led_cmd(input logic [7:0] addr, input logic [7:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/led_spi_phase.sv
// Phase and bit counters for the serial clock divider.
// clk_level, bit_tick and last_bit describe the cycle that follows the next edge.
module led_spi_phase #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 3
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic start,
  input  logic run,
  output logic clk_level,
  output logic bit_tick,
  output logic last_bit
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV / 2);
  localparam logic [BW-1:0] BIT_TOP = BW'(DATA_W - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          wrap;

  always_comb begin
    wrap    = run && (phase_q == PH_LAST);
    phase_d = '0;
    bit_d   = '0;
    if (start) begin
      bit_d = BIT_TOP;
    end else if (run) begin
      phase_d = wrap ? '0 : phase_q + PW'(1);
      bit_d   = wrap ? bit_q - BW'(1) : bit_q;
    end
    bit_tick  = wrap && (bit_q != '0);
    last_bit  = wrap && (bit_q == '0);
    // Serial clock stays low through the END cycle after the final bit.
    clk_level = (start || (run && !last_bit)) && (phase_d >= PH_HIGH);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      phase_q <= '0;
      bit_q   <= '0;
    end else begin
      phase_q <= phase_d;
      bit_q   <= bit_d;
    end
  end

endmodule

// File: rtl/led_spi_tx.sv
// Serial transmitter for the LED matrix driver: CS-framed, MSB-first words on a divided clock.
// The device latches each word on the CS rising edge that enters GAP.
//
//   state | meaning
//   IDLE  | CS high, ready for a word
//   SHIFT | CS low, bits shifted out on CLK_9M
//   END   | one cycle, CS low, CLK_9M low, DOUT holds bit 0
//   GAP   | CS high for GAP_CYC cycles before the next word
module led_spi_tx import led_pkg::*; #(
  parameter int DATA_W  = LED_WORD_W,
  parameter int CLK_DIV = LED_CLK_DIV,
  parameter int GAP_CYC = LED_GAP_CYC
) (
  input  logic              CLK_27M,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              BUSY,
  output logic              CS,
  output logic              CLK_9M,
  output logic              DOUT
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              accept, in_shift;
  logic              clk_level, bit_tick, last_bit;

  assign accept   = (state_q == IDLE) && TX_VALID;
  assign in_shift = (state_q == SHIFT);

  led_spi_phase #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk_sys   (CLK_27M),
    .rst_b     (RST_N),
    .start     (accept),
    .run       (in_shift),
    .clk_level (clk_level),
    .bit_tick  (bit_tick),
    .last_bit  (last_bit)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    gap_d   = gap_q;
    cs_d    = 1'b1;
    sclk_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (TX_VALID) begin
          state_d = SHIFT;
          sr_d    = TX_DATA;
          cs_d    = 1'b0;
        end
      end
      SHIFT: begin
        cs_d   = 1'b0;
        sclk_d = clk_level;
        // The MSB of the shift register is DOUT, so shifting only at phase 0 keeps data stable under CLK_9M high.
        if (bit_tick) sr_d = {sr_q[DATA_W-2:0], 1'b0};
        if (last_bit) state_d = END;
      end
      END: begin
        state_d = GAP;
        sr_d    = '0;
        gap_d   = GAP_LOAD;
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_27M) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sr_q    <= '0;
      gap_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      gap_q   <= gap_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
    end
  end

  assign CS       = cs_q;
  assign CLK_9M   = sclk_q;
  assign DOUT     = sr_q[DATA_W-1];
  assign TX_READY = (state_q == IDLE);
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_led_spi_tx.sv
// Bench for led_spi_tx: two instances (default timing and CLK_DIV=4/GAP_CYC=1),
// a serial-side monitor decoding frames against a queue of expected words.
module tb_led_spi_tx;
  import led_pkg::*;

  localparam int DIV0 = 3;
  localparam int GAP0 = 4;
  localparam int DIV1 = 4;
  localparam int GAP1 = 1;

  logic        clk = 1'b0;
  logic [1:0]  rst_n;
  logic [1:0]  tx_valid;
  logic [15:0] tx_data [2];
  logic [1:0]  tx_ready, busy, cs, ck9, dout;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int div_of [2];
  int gap_of [2];

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  int          prev_ck [2];
  int          nbits [2];
  int          low_run [2];
  int          high_run [2];
  int          since_fall [2];
  int          gap_run [2];
  int          cs_len [2];
  bit          aborted [2];
  bit          in_frame [2];
  bit          in_gap [2];
  logic [15:0] word [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_spi_tx #(.DATA_W(16), .CLK_DIV(DIV0), .GAP_CYC(GAP0)) u_dut0 (
    .CLK_27M (clk),        .RST_N  (rst_n[0]),
    .TX_DATA (tx_data[0]), .TX_VALID (tx_valid[0]), .TX_READY (tx_ready[0]),
    .BUSY    (busy[0]),    .CS     (cs[0]),
    .CLK_9M  (ck9[0]),     .DOUT   (dout[0])
  );

  led_spi_tx #(.DATA_W(16), .CLK_DIV(DIV1), .GAP_CYC(GAP1)) u_dut1 (
    .CLK_27M (clk),        .RST_N  (rst_n[1]),
    .TX_DATA (tx_data[1]), .TX_VALID (tx_valid[1]), .TX_READY (tx_ready[1]),
    .BUSY    (busy[1]),    .CS     (cs[1]),
    .CLK_9M  (ck9[1]),     .DOUT   (dout[1])
  );

  task automatic mon_step(input int i);
    logic [15:0] exp_w;
    bit          have;
    int          dv;
    dv = div_of[i];
    if (ck9[i] === 1'b0 && prev_ck[i] == 1) since_fall[i] = 0;
    else                                    since_fall[i]++;
    if (rst_n[i] !== 1'b1) begin
      if (in_frame[i]) aborted[i] = 1'b1;
      in_gap[i] = 1'b0;
    end
    if (cs[i] === 1'b0) begin
      if (!in_frame[i]) begin
        in_frame[i] = 1'b1;
        nbits[i] = 0; cs_len[i] = 0; low_run[i] = 0; high_run[i] = 0; word[i] = '0;
      end
      cs_len[i]++;
      if (ck9[i] === 1'b1) begin
        if (prev_ck[i] == 0) begin
          vectors++;
          if (low_run[i] != dv / 2) begin
            miscompares++;
            $display("FAIL inst%0d clk_low_run: got %0d want %0d", i, low_run[i], dv / 2);
          end
          word[i] = {word[i][14:0], dout[i]};
          nbits[i]++;
          high_run[i] = 1;
        end else high_run[i]++;
      end else begin
        if (prev_ck[i] == 1) begin
          vectors++;
          if (high_run[i] != dv - dv / 2) begin
            miscompares++;
            $display("FAIL inst%0d clk_high_run: got %0d want %0d", i, high_run[i], dv - dv / 2);
          end
          low_run[i] = 1;
        end else low_run[i]++;
      end
    end else if (in_frame[i]) begin
      in_frame[i] = 1'b0;
      if (aborted[i]) aborted[i] = 1'b0;
      else begin
        have = 1'b0;
        exp_w = '0;
        if (i == 0 && exp_q0.size() > 0) begin exp_w = exp_q0.pop_front(); have = 1'b1; end
        if (i == 1 && exp_q1.size() > 0) begin exp_w = exp_q1.pop_front(); have = 1'b1; end
        vectors++;
        if (!have || word[i] !== exp_w) begin
          miscompares++;
          $display("FAIL inst%0d word: got %h want %h (expected entry present=%0d)", i, word[i], exp_w, have);
        end
        vectors++;
        if (nbits[i] != 16) begin
          miscompares++;
          $display("FAIL inst%0d rising_edges: got %0d want 16", i, nbits[i]);
        end
        vectors++;
        if (cs_len[i] != 16 * dv + 1) begin
          miscompares++;
          $display("FAIL inst%0d cs_low_cycles: got %0d want %0d", i, cs_len[i], 16 * dv + 1);
        end
        vectors++;
        if (since_fall[i] != 1) begin
          miscompares++;
          $display("FAIL inst%0d cs_rise_after_fall: got %0d want 1", i, since_fall[i]);
        end
        in_gap[i] = 1'b1;
        gap_run[i] = 1;
      end
    end else if (in_gap[i]) begin
      if (busy[i] === 1'b1) gap_run[i]++;
      else begin
        in_gap[i] = 1'b0;
        vectors++;
        if (gap_run[i] != gap_of[i]) begin
          miscompares++;
          $display("FAIL inst%0d gap_cycles: got %0d want %0d", i, gap_run[i], gap_of[i]);
        end
      end
    end
    prev_ck[i] = (ck9[i] === 1'b1) ? 1 : 0;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      mon_step(0);
      mon_step(1);
    end
  endtask

  task automatic start_word(input int i, input logic [15:0] w, input bit push);
    tx_data[i]  = w;
    tx_valid[i] = 1'b1;
    if (push) begin
      if (i == 0) exp_q0.push_back(w);
      else        exp_q1.push_back(w);
    end
  endtask

  // Returns just after the handshake edge, i.e. in the first SHIFT cycle.
  task automatic wait_hs(input int i, output int hs);
    hs = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tx_ready[i] === 1'b1 && tx_valid[i] === 1'b1) begin
        hs = cyc;
        break;
      end
    end
    vectors++;
    if (hs < 0) begin
      miscompares++;
      $display("FAIL inst%0d handshake_wait: got timeout want handshake", i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (busy[i] === 1'b0 && cs[i] === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL inst%0d idle_wait: got busy want idle", i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({cs[i], ck9[i], dout[i], busy[i]} !== 4'b1000) begin
          miscompares++;
          $display("FAIL inst%0d reset_outputs {cs,clk,dout,busy}: got %b want 1000", i,
                   {cs[i], ck9[i], dout[i], busy[i]});
        end
      end
    end
    @(posedge clk);
    #1;
    rst_n    = 2'b11;
    tx_valid = 2'b00;
  endtask

  task automatic test_single();
    int hs;
    logic [15:0] w;
    w = led_cmd(SHUTDOWN, 8'h01);
    start_word(0, w, 1'b1);
    wait_hs(0, hs);
    tx_valid[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if ({cs[0], ck9[0], dout[0], busy[0], tx_ready[0]} !== {3'b000, 2'b10}) begin
      miscompares++;
      $display("FAIL first_shift_cycle {cs,clk,dout,busy,ready}: got %b want 00010",
               {cs[0], ck9[0], dout[0], busy[0], tx_ready[0]});
    end
    wait_idle(0);
  endtask

  task automatic test_back_to_back();
    int h1, h2;
    start_word(0, led_cmd(TEST, 8'h00), 1'b1);
    exp_q0.push_back(led_cmd(SCANLIMIT, 8'h07));
    wait_hs(0, h1);
    tx_data[0] = led_cmd(SCANLIMIT, 8'h07);
    wait_hs(0, h2);
    tx_valid[0] = 1'b0;
    vectors++;
    if (h2 - h1 != 16 * DIV0 + 2 + GAP0) begin
      miscompares++;
      $display("FAIL b2b_period: got %0d want %0d", h2 - h1, 16 * DIV0 + 2 + GAP0);
    end
    wait_idle(0);
  endtask

  task automatic test_valid_during_shift();
    int h1, h2;
    start_word(0, led_cmd(INTENSITY, 8'h05), 1'b1);
    wait_hs(0, h1);
    tx_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start_word(0, 16'hFFFF, 1'b1);
    @(negedge clk);
    vectors++;
    if (tx_ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_during_shift: got %b want 0", tx_ready[0]);
    end
    wait_hs(0, h2);
    tx_valid[0] = 1'b0;
    vectors++;
    if (h2 - h1 != 16 * DIV0 + 2 + GAP0) begin
      miscompares++;
      $display("FAIL held_word_handshake: got %0d want %0d", h2 - h1, 16 * DIV0 + 2 + GAP0);
    end
    wait_idle(0);
  endtask

  task automatic test_reset_mid_frame();
    int hs;
    start_word(0, led_cmd(DECODE, 8'h00), 1'b0);
    wait_hs(0, hs);
    tx_valid[0] = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cs[0], ck9[0], dout[0], tx_ready[0]} !== 4'b1001) begin
      miscompares++;
      $display("FAIL abort_outputs {cs,clk,dout,ready}: got %b want 1001",
               {cs[0], ck9[0], dout[0], tx_ready[0]});
    end
    @(posedge clk);
    #1;
    start_word(0, led_cmd(SHUTDOWN, 8'h01), 1'b1);
    wait_hs(0, hs);
    tx_valid[0] = 1'b0;
    wait_idle(0);
  endtask

  task automatic test_div4();
    int h1, h2;
    start_word(1, 16'hA55A, 1'b1);
    exp_q1.push_back(16'h5AA5);
    wait_hs(1, h1);
    tx_data[1] = 16'h5AA5;
    wait_hs(1, h2);
    tx_valid[1] = 1'b0;
    vectors++;
    if (h2 - h1 != 16 * DIV1 + 2 + GAP1) begin
      miscompares++;
      $display("FAIL div4_period: got %0d want %0d", h2 - h1, 16 * DIV1 + 2 + GAP1);
    end
    wait_idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    div_of[0] = DIV0; div_of[1] = DIV1;
    gap_of[0] = GAP0; gap_of[1] = GAP1;
    for (int i = 0; i < 2; i++) begin
      prev_ck[i] = 0; nbits[i] = 0; low_run[i] = 0; high_run[i] = 0;
      since_fall[i] = 0; gap_run[i] = 0; cs_len[i] = 0;
      aborted[i] = 1'b0; in_frame[i] = 1'b0; in_gap[i] = 1'b0; word[i] = '0;
    end
    rst_n      = 2'b00;
    tx_valid   = 2'b11;
    tx_data[0] = 16'hFFFF;
    tx_data[1] = 16'hFFFF;
    fork
      monitor_loop();
    join_none

    test_reset();
    test_single();
    test_back_to_back();
    test_valid_during_shift();
    test_reset_mid_frame();
    test_div4();

    repeat (3) @(posedge clk);
    vectors++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expected: got %0d/%0d want 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
